// File: rtl/avalon_burst_host.sv
`timescale 1ns/1ps
// Avalon-MM burst self-test host: writes SEED+k in maximum-length bursts, then
// reads the same region back one burst at a time and counts mismatching words.
module avalon_burst_host #(
  parameter int          ADDR_W       = 32,
  parameter int          DATA_W       = 32,
  parameter int          BURSTCOUNT_W = 4,
  parameter logic [31:0] SEED         = 32'hA5A5_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [7:0]                nbursts,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               err_count,
  output logic [ADDR_W-1:0]         address,
  output logic                      read,
  output logic                      write,
  output logic [DATA_W-1:0]         writedata,
  output logic [DATA_W/8-1:0]       byteenable,
  output logic [BURSTCOUNT_W-1:0]   burstcount,
  input  logic                      waitrequest,
  input  logic [DATA_W-1:0]         readdata,
  input  logic                      readdatavalid
);

  localparam int                    BYTES       = DATA_W / 8;
  localparam int                    LEN         = 1 << (BURSTCOUNT_W - 1);
  localparam logic [BURSTCOUNT_W-1:0] BURST_LEN = BURSTCOUNT_W'(LEN);
  localparam logic [BURSTCOUNT_W-1:0] LAST_BEAT = BURSTCOUNT_W'(LEN - 1);
  localparam logic [ADDR_W-1:0]     BURST_BYTES = ADDR_W'(LEN * BYTES);
  localparam logic [ADDR_W-1:0]     ALIGN_MASK  = ~ADDR_W'(BYTES - 1);
  localparam logic [DATA_W-1:0]     PAT_START   = DATA_W'(SEED);
  localparam logic [BYTES-1:0]      BE_ALL      = {BYTES{1'b1}};

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_DATA, FIN} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       base;
  logic [7:0]              nb;
  logic [7:0]              burst;
  logic [BURSTCOUNT_W-1:0] beat;
  logic [DATA_W-1:0]       exp_data;

  // Handshake: a command beat transfers in any cycle where read or write is
  // high and waitrequest is low; otherwise every Avalon output holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      nb         <= '0;
      burst      <= '0;
      beat       <= '0;
      exp_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      burstcount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base      <= base_addr & ALIGN_MASK;
            nb        <= nbursts;
            burst     <= '0;
            beat      <= '0;
            err_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            if (nbursts == 8'd0) begin
              state <= FIN;
            end else begin
              state      <= WR;
              write      <= 1'b1;
              address    <= base_addr & ALIGN_MASK;
              writedata  <= PAT_START;
              burstcount <= BURST_LEN;
              byteenable <= BE_ALL;
            end
          end
        end
        WR: begin
          if (!waitrequest) begin
            writedata <= writedata + DATA_W'(1);
            if (beat != LAST_BEAT) begin
              beat <= beat + BURSTCOUNT_W'(1);
            end else begin
              beat <= '0;
              if (burst != nb - 8'd1) begin
                // write stays high: the next burst follows back-to-back
                burst   <= burst + 8'd1;
                address <= address + BURST_BYTES;
              end else begin
                burst    <= '0;
                state    <= RD_REQ;
                write    <= 1'b0;
                read     <= 1'b1;
                address  <= base;
                exp_data <= PAT_START;
              end
            end
          end
        end
        RD_REQ: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            burstcount <= '0;
            byteenable <= '0;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          // only one read burst is outstanding, so beats map directly to (b, j)
          if (readdatavalid) begin
            if (readdata != exp_data && err_count != 16'hFFFF)
              err_count <= err_count + 16'd1;
            exp_data <= exp_data + DATA_W'(1);
            if (beat != LAST_BEAT) begin
              beat <= beat + BURSTCOUNT_W'(1);
            end else begin
              beat <= '0;
              if (burst != nb - 8'd1) begin
                burst      <= burst + 8'd1;
                address    <= address + BURST_BYTES;
                read       <= 1'b1;
                burstcount <= BURST_LEN;
                byteenable <= BE_ALL;
                state      <= RD_REQ;
              end else begin
                state <= FIN;
              end
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_burst_host.sv
`timescale 1ns/1ps
// Directed bench for avalon_burst_host with a behavioural burst memory agent
// and an expected-transaction scoreboard.
module tb_avalon_burst_host;

  localparam int          L    = 8;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  nbursts;
  logic        busy, done;
  logic [15:0] err_count;
  logic [31:0] address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [3:0]  burstcount;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  avalon_burst_host dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .nbursts(nbursts), .busy(busy), .done(done), .err_count(err_count),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .burstcount(burstcount),
    .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // agent configuration and state
  bit          rand_mode;
  int          lat;
  int          corrupt_k;
  bit          zero_data;
  int          wr_count, rd_bursts, rd_k;
  int          wr_beat, rd_left, rd_beat, rd_delay;
  logic [31:0] wr_burst_addr, rd_addr;
  logic [31:0] mem [logic [31:0]];
  bit          stalled;
  logic [41:0] snap_ctrl;
  logic [31:0] snap_wdata;

  // scoreboard
  logic [63:0] exp_wr_q[$];
  logic [31:0] exp_rd_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic agent();
    logic [31:0] d;
    forever begin
      @(negedge clk);
      if (reset) begin
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        wr_beat       = 0;
        rd_left       = 0;
        stalled       = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
      end else begin
        if (stalled) begin
          chk("stall_ctrl", 64'({address, burstcount, byteenable, read, write}), 64'(snap_ctrl));
          chk("stall_wdata", 64'(writedata), 64'(snap_wdata));
        end
        readdatavalid = 1'b0;
        if (rd_left > 0) begin
          if (rd_delay > 0) begin
            rd_delay--;
          end else if (!rand_mode || $urandom_range(0, 1) == 1) begin
            d = zero_data ? 32'h0 : mem[rd_addr + 32'(4 * rd_beat)];
            if (rd_k == corrupt_k) d = d ^ 32'h1;
            readdata      = d;
            readdatavalid = 1'b1;
            rd_beat++;
            rd_left--;
            rd_k++;
          end
        end
        waitrequest = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (write && !waitrequest) begin
          if (wr_beat == 0) begin
            wr_burst_addr = address;
            rd_k = 0;
          end else begin
            chk("wr_addr_held", 64'(address), 64'(wr_burst_addr));
          end
          chk("wr_bc_be", 64'({burstcount, byteenable}), 64'({4'd8, 4'hF}));
          chk("wr_beat", {wr_burst_addr + 32'(4 * wr_beat), writedata},
              (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : 64'hX);
          mem[wr_burst_addr + 32'(4 * wr_beat)] = writedata;
          wr_count++;
          wr_beat = (wr_beat == L - 1) ? 0 : wr_beat + 1;
        end
        if (read && !waitrequest) begin
          chk("rd_single_outstanding", 64'(rd_left), 64'd0);
          chk("rd_bc_be", 64'({burstcount, byteenable}), 64'({4'd8, 4'hF}));
          chk("rd_addr", 64'(address),
              (exp_rd_q.size() != 0) ? 64'(exp_rd_q.pop_front()) : 64'hX);
          rd_addr   = address;
          rd_left   = L;
          rd_beat   = 0;
          rd_delay  = lat - 1;
          rd_bursts++;
        end
        stalled    = (read || write) && waitrequest;
        snap_ctrl  = {address, burstcount, byteenable, read, write};
        snap_wdata = writedata;
      end
    end
  endtask

  task automatic push_expected(input logic [31:0] base, input int nb);
    logic [31:0] b;
    b = base & ~32'h3;
    for (int k = 0; k < nb * L; k++) exp_wr_q.push_back({b + 32'(4 * k), SEED + 32'(k)});
    for (int i = 0; i < nb; i++) exp_rd_q.push_back(b + 32'(4 * L * i));
  endtask

  // leaves the caller at the negedge of cycle t+1 (start sampled at end of t)
  task automatic pulse_start(input logic [31:0] base, input logic [7:0] nb);
    @(negedge clk);
    base_addr = base;
    nbursts   = nb;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc, output int wr_cyc, output int cmd_cyc);
    cyc = 1; wr_cyc = 0; cmd_cyc = 0;
    while (!done && cyc < budget) begin
      if (write) wr_cyc++;
      if (read || write) cmd_cyc++;
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc, wr_cyc, cmd_cyc, w0, r0;
    reset = 1'b1; start = 1'b0; base_addr = '0; nbursts = '0;
    waitrequest = 1'b0; readdata = '0; readdatavalid = 1'b0;
    rand_mode = 1'b0; lat = 1; corrupt_k = -1; zero_data = 1'b0;
    wr_count = 0; rd_bursts = 0; rd_k = 0; wr_beat = 0; rd_left = 0;
    rd_beat = 0; rd_delay = 0; stalled = 1'b0;
    snap_ctrl = '0; snap_wdata = '0; wr_burst_addr = '0; rd_addr = '0;
    fork agent(); join_none

    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, read, write}), 64'd0);
    chk("rst_addr", 64'(address), 64'd0);
    chk("rst_wdata", 64'(writedata), 64'd0);
    chk("rst_bc_be", 64'({burstcount, byteenable}), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    reset = 1'b0;

    // zero-wait agent, two bursts from 0x100
    w0 = wr_count; r0 = rd_bursts;
    push_expected(32'h100, 2);
    pulse_start(32'h100, 8'd2);
    chk("t1_write_at_t1", 64'({write, read, busy, done}), 64'b1010);
    chk("t1_first_addr", 64'(address), 64'h100);
    chk("t1_first_data", 64'(writedata), 64'(SEED));
    wait_done(200, cyc, wr_cyc, cmd_cyc);
    chk("t1_done_latency", 64'(cyc), 64'd36);
    chk("t1_write_cycles", 64'(wr_cyc), 64'd16);
    chk("t1_cmd_cycles", 64'(cmd_cyc), 64'd18);
    chk("t1_err", 64'(err_count), 64'd0);
    chk("t1_writes", 64'(wr_count - w0), 64'd16);
    chk("t1_reads", 64'(rd_bursts - r0), 64'd2);
    chk("t1_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);
    chk("t1_idle_bc_be", 64'({burstcount, byteenable}), 64'd0);

    // random waitrequest, 3-cycle read latency
    rand_mode = 1'b1; lat = 3;
    w0 = wr_count; r0 = rd_bursts;
    push_expected(32'h2000, 2);
    pulse_start(32'h2000, 8'd2);
    chk("t2_done_cleared", 64'(done), 64'd0);
    wait_done(1000, cyc, wr_cyc, cmd_cyc);
    chk("t2_err", 64'(err_count), 64'd0);
    chk("t2_writes", 64'(wr_count - w0), 64'd16);
    chk("t2_reads", 64'(rd_bursts - r0), 64'd2);
    chk("t2_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);
    rand_mode = 1'b0; lat = 1;

    // corrupt read word k=13
    corrupt_k = 13;
    push_expected(32'h800, 2);
    pulse_start(32'h800, 8'd2);
    wait_done(200, cyc, wr_cyc, cmd_cyc);
    chk("t3_err_one", 64'(err_count), 64'd1);
    corrupt_k = -1;

    // all-zero read data, 255 bursts, unaligned base that wraps the address space
    zero_data = 1'b1;
    w0 = wr_count;
    push_expected(32'hFFFF_FF03, 255);
    pulse_start(32'hFFFF_FF03, 8'd255);
    chk("t4_aligned_base", 64'(address), 64'hFFFF_FF00);
    wait_done(8000, cyc, wr_cyc, cmd_cyc);
    chk("t4_err_2040", 64'(err_count), 64'd2040);
    chk("t4_writes", 64'(wr_count - w0), 64'd2040);
    chk("t4_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);

    // saturation: preset the counter to FFFE over the first read beat
    push_expected(32'h40, 1);
    pulse_start(32'h40, 8'd1);
    for (int i = 0; i < 50 && !read; i++) @(negedge clk);
    chk("t5_read_seen", 64'(read), 64'd1);
    @(negedge clk);
    force dut.err_count = 16'hFFFE;
    @(posedge clk);
    #1 release dut.err_count;
    wait_done(200, cyc, wr_cyc, cmd_cyc);
    chk("t5_err_saturated", 64'(err_count), 64'hFFFF);
    zero_data = 1'b0;

    // start pulsed during WR with different base/nbursts is ignored
    w0 = wr_count; r0 = rd_bursts;
    push_expected(32'h300, 1);
    pulse_start(32'h300, 8'd1);
    base_addr = 32'h5000; nbursts = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, cyc, wr_cyc, cmd_cyc);
    chk("t6_writes", 64'(wr_count - w0), 64'd8);
    chk("t6_reads", 64'(rd_bursts - r0), 64'd1);
    chk("t6_err", 64'(err_count), 64'd0);
    chk("t6_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);

    // nbursts = 0: done at t+2, no command
    pulse_start(32'h0, 8'd0);
    chk("t7_busy_t1", 64'({busy, done, read, write}), 64'b1000);
    wait_done(20, cyc, wr_cyc, cmd_cyc);
    chk("t7_done_t2", 64'(cyc), 64'd2);
    chk("t7_no_cmd", 64'(cmd_cyc), 64'd0);

    // reset in the middle of the second write burst
    w0 = wr_count;
    push_expected(32'h400, 2);
    pulse_start(32'h400, 8'd2);
    for (int i = 0; i < 100 && (wr_count - w0) < 10; i++) @(negedge clk);
    chk("t8_in_burst2", 64'((wr_count - w0) >= 10), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t8_async_drop", 64'({write, read, busy, done}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    w0 = wr_count; r0 = rd_bursts;
    push_expected(32'h500, 2);
    pulse_start(32'h500, 8'd2);
    wait_done(200, cyc, wr_cyc, cmd_cyc);
    chk("t8_clean_latency", 64'(cyc), 64'd36);
    chk("t8_clean_err", 64'(err_count), 64'd0);
    chk("t8_clean_writes", 64'(wr_count - w0), 64'd16);
    chk("t8_clean_reads", 64'(rd_bursts - r0), 64'd2);
    chk("t8_queues_empty", 64'(exp_wr_q.size() + exp_rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/avalon_burst_host.md
# avalon_burst_host

Avalon-MM host (initiator) that exercises a burst-capable Avalon agent memory such as the team's block-RAM agent. On a start pulse it writes a deterministic data pattern in maximum-length bursts, then reads the same region back in bursts and compares each returned word, reporting done, busy and a saturating mismatch count. It sits on the host side of the shared Avalon bus and serves as the self-test driver for the memory controller.

## Interface
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, data width; a multiple of 8.
- `BURSTCOUNT_W`, 4, burstcount width; burst length L = 2**(BURSTCOUNT_W-1), which is 8 by default.
- `SEED`, 32'hA5A5_0000, pattern offset.

Ports:
- `clk`  in  1  sole clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle request; only sampled in IDLE.
- `base_addr`  in  ADDR_W  start byte address; its low log2(DATA_W/8) bits are forced to 0.
- `nbursts`  in  8  number of bursts per phase.
- `busy`  out  1  high from the cycle after an accepted start until the run ends.
- `done`  out  1  level; set at the end of a run, cleared by the next accepted start.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.
- `address`  out  ADDR_W  Avalon byte address.
- `read`, `write`  out  1  Avalon commands.
- `writedata`  out  DATA_W
- `byteenable`  out  DATA_W/8  all ones whenever `write` or `read` is high, 0 otherwise.
- `burstcount`  out  BURSTCOUNT_W  always L during a command, 0 otherwise.
- `waitrequest`  in  1
- `readdata`  in  DATA_W
- `readdatavalid`  in  1

## Operation
- Pattern: word index k = b*L + j, where b is the burst index and j is the beat index. The word is SEED + k, truncated or zero-extended to DATA_W.
- Burst b address: base + b*L*(DATA_W/8), modulo 2**ADDR_W (wrap-around allowed).
- The state machine has five states: IDLE, WR, RD_REQ, RD_DATA, FIN.
- IDLE:
  - On `start`, capture `base_addr` and `nbursts`, clear `err_count`, clear `done`, and set `busy`.
  - If `nbursts` is 0, go to FIN.
  - Otherwise go to WR with b=0, j=0.
- WR:
  - `write` is high with `address` and `burstcount` held constant for the whole burst.
  - `writedata` is the pattern for (b, j).
  - A beat is accepted in any cycle where `waitrequest` is 0; j then increments.
  - After beat L-1: if b < nbursts-1, increment b, set j=0 and stay in WR. `write` stays high, so back-to-back bursts are allowed.
  - After the last burst, go to RD_REQ with b=0.
- RD_REQ:
  - `read` is high with the burst-b address and `burstcount` = L, held until `waitrequest` is 0.
  - Then go to RD_DATA. `read` is low in that next cycle.
- RD_DATA:
  - Each `readdatavalid` beat is compared with the pattern for (b, j). On mismatch, `err_count` increments (saturating). j then increments.
  - After beat L-1: go to RD_REQ for the next burst, or to FIN after the last one.
  - Only one read burst is ever outstanding.
  - `readdatavalid` arriving outside RD_DATA is ignored.
- FIN: for one cycle `busy` goes to 0 and `done` goes to 1, then return to IDLE.
- `start` while not in IDLE is ignored.

## Timing
- Reset values: `busy`, `done`, `read` and `write` are 0; `address`, `writedata`, `byteenable`, `burstcount` and `err_count` are 0; state is IDLE.
- Reset asserted mid-burst drops all Avalon commands immediately (asynchronously). No completion is reported.
- All outputs are registered; there are no combinational input-to-output paths.
- Start accepted at cycle t: `write` is high at t+1.
- With zero wait states, the write phase lasts exactly nbursts*L cycles.
- Read burst:
  - The request is 1 cycle when `waitrequest` is 0.
  - The data phase lasts until the L-th `readdatavalid`.
  - The next `read` is asserted the cycle after the L-th `readdatavalid`.
- FIN:
  - FIN is entered the cycle after the last accepted read beat.
  - `busy`=0 and `done`=1 are visible the cycle after that.
  - The mismatch from the last beat is already included in `err_count` when `done` rises.
- Stall: while `waitrequest` is 1, every Avalon output keeps its value.
- `nbursts`=0: `done` rises at t+2 and no command is ever issued.

## Test plan
- Zero-wait agent, base=0x100, nbursts=2, L=8:
  - 16 writes at addresses 0x100 then 0x120, with data SEED..SEED+15.
  - Two reads, each with burstcount=8; `done`=1 and `err_count`=0.
- Agent asserts `waitrequest` randomly at 50%, with a 3-cycle read latency:
  - All data and addresses must be unchanged during stalls.
  - Expect `err_count`=0 and exactly 16 accepted writes.
- Agent corrupts read beat 5 of burst 1 (k=13) by XOR 1:
  - `err_count`=1 at `done`.
- Agent returns all-zero data with nbursts=255:
  - `err_count`=2040, no saturation.
  - Repeating with a forced counter preset at 16'hFFFE must stop at 16'hFFFF.
- `start` is pulsed during WR:
  - It is ignored, `base_addr` changes are not captured, and the transaction count is unchanged.
  - `nbursts`=0 gives `done` at t+2 with no `read` or `write`.
- `reset` is asserted in the middle of the 2nd write burst:
  - `write`, `busy` and `done` are 0 immediately.
  - After release, a new `start` runs a full clean sequence.
